fetch_redirect_ctrl: RTL and testbench

Sequencing controller for the interrupt-capable fetch/issue stage. It arbitrates every PC redirect source: stalls, branches, jumps, trap entry and mret return. It drives the fetch stage's `next_PC_select`/`target_PC`/`trap_branch`/`trap_target` inputs and squashes wrong-path instructions in decode. It sits between the execute/CSR logic and the fetch stage, and holds trap entry until the instruction-memory read port is idle.

---
 rtl/fetch_redirect_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Arbitrates every PC redirect source for the fetch stage: stalls, branches,
// jumps, mret and trap entry. It squashes wrong-path instructions in decode
// and holds trap entry until the instruction-memory port is idle.
module fetch_redirect_ctrl #(
  parameter int ADDRESS_BITS = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall_in,
  input  logic                    branch_taken,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    jump_valid,
  input  logic [ADDRESS_BITS-1:0] jump_target,
  input  logic                    mret_req,
  input  logic [ADDRESS_BITS-1:0] mepc,
  input  logic                    trap_req,
  input  logic [ADDRESS_BITS-1:0] trap_vector,
  input  logic                    i_mem_ready,
  input  logic                    scan,
  output logic [1:0]              next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    trap_branch,
  output logic [ADDRESS_BITS-1:0] trap_target,
  output logic                    trap_ack,
  output logic                    flush_decode,
  output logic [15:0]             redirect_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    TRAP_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_HOLD   = 2'b01;
  localparam logic [1:0] SEL_TARGET = 2'b10;

  // The redirect cycle itself is the first flush cycle, so FLUSH covers the
  // remaining FLUSH_CYCLES-1 cycles; a single-cycle flush stays in RUN.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam state_t     COMMIT_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              flush_count;
  logic [3:0]              flush_count_next;
  logic [ADDRESS_BITS-1:0] trap_vector_q;
  logic                    latch_vector;
  logic                    commit;
  logic                    reset_hold;

  // The trace enable only matters to simulation tooling; it has no hardware effect.
  logic unused_scan;
  assign unused_scan = scan;

  // Redirect decode: outputs are combinational from state and live requests.
  always_comb begin
    state_next       = state;
    flush_count_next = flush_count;
    latch_vector     = 1'b0;
    commit           = 1'b0;
    next_PC_select   = SEL_SEQ;
    target_PC        = '0;
    trap_branch      = 1'b0;
    trap_target      = '0;
    trap_ack         = 1'b0;
    flush_decode     = 1'b0;

    if (reset || reset_hold) begin
      flush_decode = 1'b1;
    end else begin
      case (state)
        RUN, FLUSH: begin
          if (trap_req) begin
            flush_decode = 1'b1;
            if (i_mem_ready) begin
              trap_branch      = 1'b1;
              trap_target      = trap_vector;
              trap_ack         = 1'b1;
              commit           = 1'b1;
              state_next       = COMMIT_STATE;
              flush_count_next = FLUSH_RELOAD;
            end else begin
              next_PC_select = SEL_HOLD;
              latch_vector   = 1'b1;
              state_next     = TRAP_WAIT;
            end
          end else if (state == FLUSH) begin
            flush_decode = 1'b1;
            if (flush_count <= 4'd1) begin
              state_next       = RUN;
              flush_count_next = '0;
            end else begin
              flush_count_next = flush_count - 4'd1;
            end
          end else if (mret_req || branch_taken || jump_valid) begin
            next_PC_select   = SEL_TARGET;
            flush_decode     = 1'b1;
            commit           = 1'b1;
            state_next       = COMMIT_STATE;
            flush_count_next = FLUSH_RELOAD;
            if (mret_req) begin
              target_PC = mepc;
            end else if (branch_taken) begin
              target_PC = branch_target;
            end else begin
              target_PC = jump_target;
            end
          end else if (stall_in) begin
            next_PC_select = SEL_HOLD;
          end
        end
        TRAP_WAIT: begin
          next_PC_select = SEL_HOLD;
          flush_decode   = 1'b1;
          if (i_mem_ready) begin
            trap_branch      = 1'b1;
            trap_target      = trap_vector_q;
            trap_ack         = 1'b1;
            commit           = 1'b1;
            state_next       = COMMIT_STATE;
            flush_count_next = FLUSH_RELOAD;
          end
        end
        default: begin
          state_next       = RUN;
          flush_count_next = '0;
        end
      endcase
    end
  end

  // State, flush counter, latched trap vector and saturating redirect counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      flush_count    <= '0;
      trap_vector_q  <= '0;
      redirect_count <= '0;
      reset_hold     <= 1'b1;
    end else begin
      reset_hold  <= 1'b0;
      state       <= state_next;
      flush_count <= flush_count_next;
      if (latch_vector) begin
        trap_vector_q <= trap_vector;
      end
      if (commit && (redirect_count != 16'hFFFF)) begin
        redirect_count <= redirect_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: a per-cycle vector table on a default
// instance, plus a second instance with a one-cycle flush used to saturate
// the redirect counter and to reset it in the middle of a trap wait.
module tb_fetch_redirect_ctrl;

  logic clock = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Main instance signals (default parameters).
  logic        reset = 1'b1;
  logic        stall_in = 1'b0, branch_taken = 1'b0, jump_valid = 1'b0, mret_req = 1'b0;
  logic        trap_req = 1'b0, i_mem_ready = 1'b1, scan = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, mepc = '0, trap_vector = '0;
  logic [1:0]  next_PC_select;
  logic [31:0] target_PC, trap_target;
  logic        trap_branch, trap_ack, flush_decode;
  logic [15:0] redirect_count;

  // Second instance signals (single-cycle flush).
  logic        reset_s = 1'b1;
  logic        stall_s = 1'b0, branch_s = 1'b0, jump_s = 1'b0, mret_s = 1'b0;
  logic        trap_s = 1'b0, ready_s = 1'b1;
  logic [31:0] branch_tgt_s = '0, jump_tgt_s = '0, mepc_s = '0, vector_s = '0;
  logic [1:0]  sel_s;
  logic [31:0] target_s, trap_tgt_s;
  logic        trap_branch_s, trap_ack_s, flush_s;
  logic [15:0] count_s;

  fetch_redirect_ctrl #(.ADDRESS_BITS(32), .FLUSH_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .stall_in(stall_in),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .mret_req(mret_req), .mepc(mepc),
    .trap_req(trap_req), .trap_vector(trap_vector),
    .i_mem_ready(i_mem_ready), .scan(scan),
    .next_PC_select(next_PC_select), .target_PC(target_PC),
    .trap_branch(trap_branch), .trap_target(trap_target),
    .trap_ack(trap_ack), .flush_decode(flush_decode),
    .redirect_count(redirect_count)
  );

  fetch_redirect_ctrl #(.ADDRESS_BITS(32), .FLUSH_CYCLES(1)) dut_short (
    .clock(clock), .reset(reset_s), .stall_in(stall_s),
    .branch_taken(branch_s), .branch_target(branch_tgt_s),
    .jump_valid(jump_s), .jump_target(jump_tgt_s),
    .mret_req(mret_s), .mepc(mepc_s),
    .trap_req(trap_s), .trap_vector(vector_s),
    .i_mem_ready(ready_s), .scan(scan),
    .next_PC_select(sel_s), .target_PC(target_s),
    .trap_branch(trap_branch_s), .trap_target(trap_tgt_s),
    .trap_ack(trap_ack_s), .flush_decode(flush_s),
    .redirect_count(count_s)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jv;
    logic [31:0] j_tgt;
    logic        mret;
    logic [31:0] mepc;
    logic        trap;
    logic [31:0] tv;
    logic        ready;
    logic [1:0]  e_sel;
    logic [31:0] e_tgt;
    logic        e_tb;
    logic [31:0] e_tt;
    logic        e_ack;
    logic        e_flush;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic stall, input logic br, input logic [31:0] br_tgt,
                         input logic jv, input logic [31:0] j_tgt,
                         input logic mret, input logic [31:0] mepc_v,
                         input logic trap, input logic [31:0] tv, input logic ready,
                         input logic [1:0] e_sel, input logic [31:0] e_tgt,
                         input logic e_tb, input logic [31:0] e_tt, input logic e_ack,
                         input logic e_flush, input logic [15:0] e_count);
    vec_t v;
    v.stall = stall; v.br = br; v.br_tgt = br_tgt; v.jv = jv; v.j_tgt = j_tgt;
    v.mret = mret; v.mepc = mepc_v; v.trap = trap; v.tv = tv; v.ready = ready;
    v.e_sel = e_sel; v.e_tgt = e_tgt; v.e_tb = e_tb; v.e_tt = e_tt;
    v.e_ack = e_ack; v.e_flush = e_flush; v.e_count = e_count;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    stall_in      = v.stall;
    branch_taken  = v.br;
    branch_target = v.br_tgt;
    jump_valid    = v.jv;
    jump_target   = v.j_tgt;
    mret_req      = v.mret;
    mepc          = v.mepc;
    trap_req      = v.trap;
    trap_vector   = v.tv;
    i_mem_ready   = v.ready;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_row(input int i, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", i);
    check_output({tag, " next_PC_select"}, 32'(next_PC_select), 32'(v.e_sel));
    check_output({tag, " target_PC"}, target_PC, v.e_tgt);
    check_output({tag, " trap_branch"}, 32'(trap_branch), 32'(v.e_tb));
    check_output({tag, " trap_target"}, trap_target, v.e_tt);
    check_output({tag, " trap_ack"}, 32'(trap_ack), 32'(v.e_ack));
    check_output({tag, " flush_decode"}, 32'(flush_decode), 32'(v.e_flush));
    check_output({tag, " redirect_count"}, 32'(redirect_count), 32'(v.e_count));
  endtask

  // Safety net in case the run stalls.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    //       stl br  btgt        jv  jtgt        mr  mepc        tr  tv          rdy  sel    tgt         tb  tt          ack fl  cnt
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 0, 16'd0);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 0, 16'd0);
    add_vec(1, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b01, 32'h0,      0, 32'h0,      0, 0, 16'd0);
    add_vec(0, 1, 32'h8000,   0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b10, 32'h8000,   0, 32'h0,      0, 1, 16'd0);
    add_vec(0, 1, 32'h9000,   0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd1);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 0, 16'd1);
    add_vec(1, 0, 32'h0,      1, 32'h1234,   0, 32'h0,      0, 32'h0,      1, 2'b10, 32'h1234,   0, 32'h0,      0, 1, 16'd1);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd2);
    add_vec(0, 1, 32'h2000,   1, 32'h3000,   0, 32'h0,      0, 32'h0,      1, 2'b10, 32'h2000,   0, 32'h0,      0, 1, 16'd2);
    add_vec(1, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd3);
    add_vec(0, 1, 32'h5000,   0, 32'h0,      1, 32'h400,    0, 32'h0,      1, 2'b10, 32'h400,    0, 32'h0,      0, 1, 16'd3);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd4);
    add_vec(0, 1, 32'h8000,   0, 32'h0,      0, 32'h0,      1, 32'hC0,     1, 2'b00, 32'h0,      1, 32'hC0,     1, 1, 16'd4);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd5);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 0, 16'd5);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'hC0,     0, 2'b01, 32'h0,      0, 32'h0,      0, 1, 16'd5);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h100,    0, 2'b01, 32'h0,      0, 32'h0,      0, 1, 16'd5);
    add_vec(0, 1, 32'h7000,   0, 32'h0,      0, 32'h0,      1, 32'h100,    0, 2'b01, 32'h0,      0, 32'h0,      0, 1, 16'd5);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h100,    1, 2'b01, 32'h0,      1, 32'hC0,     1, 1, 16'd5);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd6);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 0, 16'd6);
    add_vec(0, 0, 32'h0,      1, 32'h10,     0, 32'h0,      0, 32'h0,      1, 2'b10, 32'h10,     0, 32'h0,      0, 1, 16'd6);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h200,    1, 2'b00, 32'h0,      1, 32'h200,    1, 1, 16'd7);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd8);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 0, 16'd8);
    add_vec(0, 0, 32'h0,      0, 32'h0,      1, 32'h500,    0, 32'h0,      0, 2'b10, 32'h500,    0, 32'h0,      0, 1, 16'd8);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 1, 16'd9);
    add_vec(0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 2'b00, 32'h0,      0, 32'h0,      0, 0, 16'd9);

    // Reset held for three cycles: outputs forced, counter cleared.
    repeat (3) @(posedge clock);
    #4;
    check_output("reset next_PC_select", 32'(next_PC_select), 32'h0);
    check_output("reset flush_decode", 32'(flush_decode), 32'h1);
    check_output("reset trap_ack", 32'(trap_ack), 32'h0);
    check_output("reset redirect_count", 32'(redirect_count), 32'h0);

    // First cycle after reset is still forced.
    @(posedge clock);
    #1;
    reset   = 1'b0;
    reset_s = 1'b0;
    #3;
    check_output("post-reset flush_decode", 32'(flush_decode), 32'h1);
    check_output("post-reset next_PC_select", 32'(next_PC_select), 32'h0);
    check_output("post-reset trap_branch", 32'(trap_branch), 32'h0);

    foreach (vecs[i]) begin
      @(posedge clock);
      #1;
      apply_stimulus(vecs[i]);
      #3;
      check_row(i, vecs[i]);
    end

    // Saturate the counter on the single-cycle-flush instance with 65536 jumps.
    @(posedge clock);
    #1;
    jump_s     = 1'b1;
    jump_tgt_s = 32'h40;
    for (int n = 0; n < 65536; n++) begin
      #3;
      if (n == 0) begin
        check_output("sat first next_PC_select", 32'(sel_s), 32'h2);
        check_output("sat first target_PC", target_s, 32'h40);
        check_output("sat first flush_decode", 32'(flush_s), 32'h1);
        check_output("sat first redirect_count", 32'(count_s), 32'h0);
      end
      if (n == 65534) begin
        check_output("sat near-full redirect_count", 32'(count_s), 32'hFFFE);
      end
      @(posedge clock);
      #1;
    end
    for (int n = 0; n < 4; n++) begin
      #3;
      check_output("sat held redirect_count", 32'(count_s), 32'hFFFF);
      @(posedge clock);
      #1;
    end

    // Enter TRAP_WAIT, then reset while the memory port becomes ready.
    jump_s   = 1'b0;
    trap_s   = 1'b1;
    vector_s = 32'h300;
    ready_s  = 1'b0;
    #3;
    check_output("wait entry next_PC_select", 32'(sel_s), 32'h1);
    check_output("wait entry trap_ack", 32'(trap_ack_s), 32'h0);
    @(posedge clock);
    #1;
    reset_s = 1'b1;
    ready_s = 1'b1;
    #3;
    check_output("reset-in-wait trap_ack", 32'(trap_ack_s), 32'h0);
    check_output("reset-in-wait trap_branch", 32'(trap_branch_s), 32'h0);
    check_output("reset-in-wait flush_decode", 32'(flush_s), 32'h1);
    @(posedge clock);
    #1;
    reset_s = 1'b0;
    trap_s  = 1'b0;
    #3;
    check_output("after reset redirect_count", 32'(count_s), 32'h0);
    check_output("after reset trap_ack", 32'(trap_ack_s), 32'h0);
    @(posedge clock);
    #1;
    #3;
    check_output("discarded trap trap_ack", 32'(trap_ack_s), 32'h0);
    check_output("discarded trap next_PC_select", 32'(sel_s), 32'h0);
    check_output("discarded trap flush_decode", 32'(flush_s), 32'h0);
    check_output("discarded trap redirect_count", 32'(count_s), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
